fpu_div_exp_ctl: RTL and testbench

Sequencing controller for the FPU divide exponent datapath. Accepts one divide request at a time. Drives the operand load, the adder-1 and adder-2 operand selects, and the register load enables across stages D1–D7, with an iteration hold between D4 and D5. Gates the divide-pipe clock when idle and returns completion to the FPU issue logic through a valid/ready handshake.

---
 rtl/fpu_div_exp_ctl.sv | 140 ++++++++++++++
 tb/tb_fpu_div_exp_ctl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_div_exp_ctl.sv
// Sequencing controller for the FPU divide exponent datapath: steps one divide
// through D1-D7 with a mantissa iteration hold, then hands the result back.
module fpu_div_exp_ctl #(
    parameter int ITER_DBL = 54,
    parameter int ITER_SNG = 25,
    parameter int CNT_W    = 6
) (
    input  logic       rclk,
    input  logic       arst_l,
    input  logic       req_vld,
    input  logic       req_dbl,
    input  logic [1:0] req_spc,
    output logic       req_rdy,
    input  logic       kill,
    output logic       res_vld,
    input  logic       res_rdy,
    output logic       busy,
    output logic       d1stg_step,
    output logic       div_expadd1_in1_dbl,
    output logic       div_expadd1_in1_sng,
    output logic       div_expadd1_in2_exp_in2_dbl,
    output logic       div_expadd1_in2_exp_in2_sng,
    output logic       d234stg_fdiv,
    output logic       d3stg_fdiv,
    output logic       d4stg_fdiv,
    output logic       div_exp1_expadd1,
    output logic       div_exp1_0835,
    output logic       div_exp1_0118,
    output logic       div_exp1_zero,
    output logic       div_exp1_load,
    output logic       d5stg_fdiva,
    output logic       d5stg_fdivd,
    output logic       d5stg_fdivs,
    output logic       d6stg_fdiv,
    output logic       d7stg_fdiv,
    output logic       div_expadd2_in1_exp_out,
    output logic       div_exp_out_expadd2,
    output logic       div_exp_out_exp_out,
    output logic       div_exp_out_load,
    output logic       fdiv_clken_l
);

    typedef enum logic [3:0] {
        IDLE, D1, D2, D3, D4, ITER, D5, D6, D7, DONE
    } state_t;

    localparam logic [CNT_W-1:0] LOAD_DBL = CNT_W'(ITER_DBL - 1);
    localparam logic [CNT_W-1:0] LOAD_SNG = CNT_W'(ITER_SNG - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             dbl_q;
    logic [1:0]       spc_q;
    logic             accept;
    logic             nrm;
    logic             in_d1, in_d2, in_d3, in_d4, in_d5, in_d6, in_d7;

    assign accept = req_vld & req_rdy;

    // kill overrides every non-IDLE transition; counter is loaded in D4 so ITER lasts exactly ITER_x cycles
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            state <= IDLE;
            cnt   <= '0;
            dbl_q <= 1'b0;
            spc_q <= 2'd0;
        end else if (kill && state != IDLE) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    state <= D1;
                    dbl_q <= req_dbl;
                    spc_q <= req_spc;
                end
                D1:   state <= D2;
                D2:   state <= D3;
                D3:   state <= D4;
                D4: begin
                    cnt   <= dbl_q ? LOAD_DBL : LOAD_SNG;
                    state <= ITER;
                end
                ITER: if (cnt == '0) state <= D5;
                      else           cnt   <= cnt - CNT_W'(1);
                D5:   state <= D6;
                D6:   state <= D7;
                D7:   state <= DONE;
                DONE: if (res_rdy) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign nrm   = (spc_q == 2'd0);
    assign in_d1 = (state == D1);
    assign in_d2 = (state == D2);
    assign in_d3 = (state == D3);
    assign in_d4 = (state == D4);
    assign in_d5 = (state == D5);
    assign in_d6 = (state == D6);
    assign in_d7 = (state == D7);

    assign req_rdy      = (state == IDLE) & ~kill;
    assign d1stg_step   = accept;
    assign busy         = (state != IDLE);
    assign res_vld      = (state == DONE) & ~kill;
    assign fdiv_clken_l = ~(busy | req_vld);

    // A special exponent forces div_exp1 once in D1; D2-D4 keep sequencing but must not overwrite it
    assign div_expadd1_in1_dbl         = in_d1 & nrm & dbl_q;
    assign div_expadd1_in1_sng         = in_d1 & nrm & ~dbl_q;
    assign div_expadd1_in2_exp_in2_dbl = in_d2 & dbl_q;
    assign div_expadd1_in2_exp_in2_sng = in_d2 & ~dbl_q;
    assign d234stg_fdiv                = in_d2 | in_d3 | in_d4;
    assign d3stg_fdiv                  = in_d3;
    assign d4stg_fdiv                  = in_d4;
    assign div_exp1_expadd1            = (in_d1 & nrm) | in_d2 | in_d3 | in_d4;
    assign div_exp1_0835               = in_d1 & (spc_q == 2'd1);
    assign div_exp1_0118               = in_d1 & (spc_q == 2'd2);
    assign div_exp1_zero               = in_d1 & (spc_q == 2'd3);
    assign div_exp1_load               = ~kill & (in_d1 | (nrm & (in_d2 | in_d3 | in_d4)));

    assign d5stg_fdiva             = in_d5;
    assign d5stg_fdivd             = in_d5 & dbl_q;
    assign d5stg_fdivs             = in_d5 & ~dbl_q;
    assign d6stg_fdiv              = in_d6;
    assign d7stg_fdiv              = in_d7;
    assign div_expadd2_in1_exp_out = in_d6 | in_d7;
    assign div_exp_out_expadd2     = in_d5 | in_d6 | in_d7;
    assign div_exp_out_exp_out     = in_d7;
    assign div_exp_out_load        = ~kill & (in_d5 | in_d6 | in_d7);

    stage_onehot: assert property (@(posedge rclk) disable iff (!arst_l)
        $onehot0({d3stg_fdiv, d4stg_fdiv, d5stg_fdiva, d6stg_fdiv, d7stg_fdiv}));
    exp1_sel_onehot: assert property (@(posedge rclk) disable iff (!arst_l)
        $onehot0({div_exp1_expadd1, div_exp1_0835, div_exp1_0118, div_exp1_zero}));
    d5_prec_onehot: assert property (@(posedge rclk) disable iff (!arst_l)
        $onehot0({d5stg_fdivd, d5stg_fdivs}));

endmodule

// File: tb/tb_fpu_div_exp_ctl.sv
// Bench for fpu_div_exp_ctl: a timeline model (cycles since accept) checked
// against every DUT output each cycle, plus directed literal latency checks.
module tb_fpu_div_exp_ctl;

    localparam int ITER_DBL = 54;
    localparam int ITER_SNG = 25;

    logic       rclk = 1'b0;
    logic       arst_l = 1'b0;
    logic       req_vld = 1'b0;
    logic       req_dbl = 1'b0;
    logic [1:0] req_spc = 2'd0;
    logic       kill = 1'b0;
    logic       res_rdy = 1'b0;
    logic       req_rdy, res_vld, busy, d1stg_step;
    logic       div_expadd1_in1_dbl, div_expadd1_in1_sng;
    logic       div_expadd1_in2_exp_in2_dbl, div_expadd1_in2_exp_in2_sng;
    logic       d234stg_fdiv, d3stg_fdiv, d4stg_fdiv;
    logic       div_exp1_expadd1, div_exp1_0835, div_exp1_0118, div_exp1_zero, div_exp1_load;
    logic       d5stg_fdiva, d5stg_fdivd, d5stg_fdivs, d6stg_fdiv, d7stg_fdiv;
    logic       div_expadd2_in1_exp_out, div_exp_out_expadd2, div_exp_out_exp_out;
    logic       div_exp_out_load, fdiv_clken_l;

    int n_checks = 0;
    int n_fail   = 0;

    fpu_div_exp_ctl #(.ITER_DBL(ITER_DBL), .ITER_SNG(ITER_SNG), .CNT_W(6)) dut (
        .rclk(rclk), .arst_l(arst_l), .req_vld(req_vld), .req_dbl(req_dbl),
        .req_spc(req_spc), .req_rdy(req_rdy), .kill(kill), .res_vld(res_vld),
        .res_rdy(res_rdy), .busy(busy), .d1stg_step(d1stg_step),
        .div_expadd1_in1_dbl(div_expadd1_in1_dbl), .div_expadd1_in1_sng(div_expadd1_in1_sng),
        .div_expadd1_in2_exp_in2_dbl(div_expadd1_in2_exp_in2_dbl),
        .div_expadd1_in2_exp_in2_sng(div_expadd1_in2_exp_in2_sng),
        .d234stg_fdiv(d234stg_fdiv), .d3stg_fdiv(d3stg_fdiv), .d4stg_fdiv(d4stg_fdiv),
        .div_exp1_expadd1(div_exp1_expadd1), .div_exp1_0835(div_exp1_0835),
        .div_exp1_0118(div_exp1_0118), .div_exp1_zero(div_exp1_zero),
        .div_exp1_load(div_exp1_load), .d5stg_fdiva(d5stg_fdiva), .d5stg_fdivd(d5stg_fdivd),
        .d5stg_fdivs(d5stg_fdivs), .d6stg_fdiv(d6stg_fdiv), .d7stg_fdiv(d7stg_fdiv),
        .div_expadd2_in1_exp_out(div_expadd2_in1_exp_out),
        .div_exp_out_expadd2(div_exp_out_expadd2), .div_exp_out_exp_out(div_exp_out_exp_out),
        .div_exp_out_load(div_exp_out_load), .fdiv_clken_l(fdiv_clken_l)
    );

    always #5 rclk = ~rclk;

    logic [25:0] dut_vec;
    assign dut_vec = {req_rdy, res_vld, busy, d1stg_step,
                      div_expadd1_in1_dbl, div_expadd1_in1_sng,
                      div_expadd1_in2_exp_in2_dbl, div_expadd1_in2_exp_in2_sng,
                      d234stg_fdiv, d3stg_fdiv, d4stg_fdiv,
                      div_exp1_expadd1, div_exp1_0835, div_exp1_0118, div_exp1_zero, div_exp1_load,
                      d5stg_fdiva, d5stg_fdivd, d5stg_fdivs, d6stg_fdiv, d7stg_fdiv,
                      div_expadd2_in1_exp_out, div_exp_out_expadd2, div_exp_out_exp_out,
                      div_exp_out_load, fdiv_clken_l};

    // Model: one op is a timeline t = cycles since accept (t=1 is D1, t=8+N is the result-waiting cycle)
    bit       m_act = 1'b0;
    int       m_t   = 0;
    bit       m_dbl = 1'b0;
    bit [1:0] m_spc = 2'd0;

    function automatic int iter_len(input bit dbl);
        return dbl ? ITER_DBL : ITER_SNG;
    endfunction

    always @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            m_act = 1'b0;
            m_t   = 0;
        end else if (m_act) begin
            if (kill)                                       m_act = 1'b0;
            else if (m_t >= 8 + iter_len(m_dbl) && res_rdy) m_act = 1'b0;
            else if (m_t <  8 + iter_len(m_dbl))            m_t   = m_t + 1;
        end else if (req_vld && !kill) begin
            m_act = 1'b1;
            m_t   = 1;
            m_dbl = req_dbl;
            m_spc = req_spc;
        end
    end

    function automatic logic [25:0] expect_vec();
        int  n    = iter_len(m_dbl);
        bit  st1  = m_act && m_t == 1;
        bit  st2  = m_act && m_t == 2;
        bit  st3  = m_act && m_t == 3;
        bit  st4  = m_act && m_t == 4;
        bit  st5  = m_act && m_t == 5 + n;
        bit  st6  = m_act && m_t == 6 + n;
        bit  st7  = m_act && m_t == 7 + n;
        bit  fin  = m_act && m_t == 8 + n;
        bit  plain = (m_spc == 2'd0);
        bit  front = st2 || st3 || st4;
        bit  back  = st5 || st6 || st7;
        return {!m_act && !kill, fin && !kill, m_act, !m_act && req_vld && !kill,
                st1 && plain && m_dbl, st1 && plain && !m_dbl,
                st2 && m_dbl, st2 && !m_dbl,
                front, st3, st4,
                (st1 && plain) || front, st1 && m_spc == 2'd1, st1 && m_spc == 2'd2,
                st1 && m_spc == 2'd3, !kill && (st1 || (plain && front)),
                st5, st5 && m_dbl, st5 && !m_dbl, st6, st7,
                st6 || st7, back, st7, !kill && back,
                !(m_act || req_vld)};
    endfunction

    always @(negedge rclk) begin
        logic [25:0] exp_v;
        exp_v = expect_vec();
        n_checks++;
        if (dut_vec !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL cycle_outputs t=%0t got=%h expected=%h", $time, dut_vec, exp_v);
        end
    end

    task automatic check_output(input string name, input logic actual, input logic expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s t=%0t got=%b expected=%b", name, $time, actual, expected);
        end
    endtask

    task automatic check_count(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s got=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Starts at #1 after a posedge (sync=0) or waits for one; cycle 0 is the accept cycle
    task automatic apply_stimulus(input bit sync, input bit dbl, input bit [1:0] spc,
                                  input int hold, input int kill_at, input int rst_at,
                                  input int exp_lat, input int exp_loads, input string name);
        int cyc = 0;
        int loads = 0;
        bit got = 1'b0;
        if (sync) begin
            @(posedge rclk); #1;
        end
        req_vld = 1'b1; req_dbl = dbl; req_spc = spc; res_rdy = (hold == 0);
        @(negedge rclk);
        check_output({name, "_step"}, d1stg_step, 1'b1);
        while (cyc < 200 && !got) begin
            @(posedge rclk); #1;
            cyc++;
            req_vld = 1'b0; req_dbl = 1'($urandom); req_spc = 2'($urandom);
            if (cyc == rst_at) begin
                arst_l = 1'b0;
                #1;
                check_output({name, "_rst_busy"}, busy, 1'b0);
                check_output({name, "_rst_rdy"}, req_rdy, 1'b1);
                check_output({name, "_rst_clken"}, fdiv_clken_l, 1'b1);
                check_output({name, "_rst_vld"}, res_vld, 1'b0);
                check_output({name, "_rst_load"}, div_exp_out_load, 1'b0);
                @(posedge rclk); #1;
                arst_l = 1'b1;
                return;
            end
            if (cyc == kill_at) kill = 1'b1;
            @(negedge rclk);
            if (div_exp1_load) loads++;
            if (res_vld) got = 1'b1;
            if (kill) begin
                @(posedge rclk); #1;
                kill = 1'b0;
                check_output({name, "_kill_busy"}, busy, 1'b0);
                return;
            end
        end
        if (!got) begin
            n_checks++; n_fail++;
            $display("[TB] FAIL %s_timeout no res_vld within 200 cycles", name);
            return;
        end
        check_count({name, "_latency"}, cyc, exp_lat);
        check_count({name, "_exp1_loads"}, loads, exp_loads);
        if (hold > 0) begin
            repeat (hold) begin
                @(posedge rclk); #1;
                req_vld = 1'b1;
                @(negedge rclk);
                check_output({name, "_hold_vld"}, res_vld, 1'b1);
                check_output({name, "_hold_load"}, div_exp_out_load, 1'b0);
            end
            @(posedge rclk); #1;
            req_vld = 1'b0; res_rdy = 1'b1;
        end
        @(posedge rclk); #1;
        res_rdy = 1'b0;
        @(negedge rclk);
        check_output({name, "_rdy_back"}, req_rdy, 1'b1);
        check_output({name, "_vld_gone"}, res_vld, 1'b0);
    endtask

    initial begin
        #2;
        check_output("reset_rdy", req_rdy, 1'b1);
        check_output("reset_clken", fdiv_clken_l, 1'b1);
        check_output("reset_busy", busy, 1'b0);
        check_output("reset_vld", res_vld, 1'b0);
        repeat (2) @(posedge rclk);
        #1 arst_l = 1'b1;

        $display("[TB] directed operations");
        apply_stimulus(1'b1, 1'b1, 2'd0, 0, -1, -1, 62, 4, "dbl");
        apply_stimulus(1'b1, 1'b0, 2'd0, 0, -1, -1, 33, 4, "sng");
        apply_stimulus(1'b1, 1'b1, 2'd2, 0, -1, -1, 62, 1, "spc2");
        apply_stimulus(1'b1, 1'b0, 2'd1, 5, -1, -1, 33, 1, "hold");
        apply_stimulus(1'b1, 1'b1, 2'd0, 0, 38, -1, 0, 0, "kill");
        apply_stimulus(1'b0, 1'b0, 2'd3, 0, -1, -1, 33, 1, "after_kill");
        apply_stimulus(1'b1, 1'b1, 2'd0, 0, -1, 60, 0, 0, "rst_d6");

        $display("[TB] randomized traffic");
        for (int i = 0; i < 4000; i++) begin
            @(posedge rclk); #1;
            req_vld = ($urandom_range(0, 3) == 0);
            req_dbl = 1'($urandom);
            req_spc = 2'($urandom);
            res_rdy = 1'($urandom);
            kill    = ($urandom_range(0, 79) == 0);
            arst_l  = ($urandom_range(0, 999) != 0);
        end
        @(posedge rclk); #1;
        arst_l = 1'b1; kill = 1'b0; req_vld = 1'b0;
        repeat (2) @(posedge rclk);
        @(negedge rclk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
